mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that produces the HI/LO result pair (high_out/low_out) for the processor datapath.
- Generalises the fixed 16-bit HI/LO path to any WIDTH.
- Adds signed and unsigned modes, divide-by-zero reporting and a start/busy/done handshake.
- Sits beside the ALU: operands come from the register-file rs/rt read ports, and results feed the HI/LO registers and the status register (SR).

---
 rtl/mul_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit producing the HI/LO pair for the datapath.
// Shift-add multiply and restoring divide, one iteration per clock, sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] low_out,
    output logic [WIDTH-1:0] high_out,
    output logic             dz,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     a_mag_r, b_mag_r, a_raw_r;
    logic                 sign_a_r, sign_b_r, is_div_r, by_zero_r;
    logic                 busy_r, done_r, dz_r, zero_r;
    logic [WIDTH-1:0]     low_r, high_r;

    logic                 op_signed_s, b_is_zero_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   mul_step_s, div_step_s, prod_s;
    logic [WIDTH-1:0]     res_lo_s, res_hi_s;
    logic                 res_dz_s;

    assign op_signed_s = SIGNED_EN ? op[0] : 1'b0;
    assign b_is_zero_s = (b == {WIDTH{1'b0}});
    assign a_mag_s     = (op_signed_s && a[WIDTH-1]) ? neg_w(a) : a;
    assign b_mag_s     = (op_signed_s && b[WIDTH-1]) ? neg_w(b) : b;

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}});
        mul_step_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_mag_r});
        div_diff_s  = div_shift_s - {1'b0, b_mag_r};
        if (div_ge_s) begin
            div_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero substitution for the final cycle
    always_comb begin
        prod_s   = (sign_a_r ^ sign_b_r) ? neg_2w(acc_r) : acc_r;
        res_lo_s = prod_s[WIDTH-1:0];
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_dz_s = 1'b0;
        if (by_zero_r) begin
            res_lo_s = {WIDTH{1'b1}};
            res_hi_s = a_raw_r;
            res_dz_s = 1'b1;
        end else if (is_div_r) begin
            res_lo_s = (sign_a_r ^ sign_b_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            res_hi_s = sign_a_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        end else begin
            res_lo_s = prod_s[WIDTH-1:0];
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            a_mag_r   <= {WIDTH{1'b0}};
            b_mag_r   <= {WIDTH{1'b0}};
            a_raw_r   <= {WIDTH{1'b0}};
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            is_div_r  <= 1'b0;
            by_zero_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            zero_r    <= 1'b0;
            low_r     <= {WIDTH{1'b0}};
            high_r    <= {WIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_raw_r   <= a;
                        a_mag_r   <= a_mag_s;
                        b_mag_r   <= b_mag_s;
                        sign_a_r  <= op_signed_s & a[WIDTH-1];
                        sign_b_r  <= op_signed_s & b[WIDTH-1];
                        is_div_r  <= op[1];
                        by_zero_r <= op[1] & b_is_zero_s;
                        busy_r    <= 1'b1;
                        acc_r     <= {{WIDTH{1'b0}}, (op[1] ? a_mag_s : b_mag_s)};
                        // Divide-by-zero skips the iterations but keeps one settling cycle
                        cnt_r     <= (op[1] && b_is_zero_s) ? LAST : {CW{1'b0}};
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (!by_zero_r) begin
                        acc_r <= is_div_r ? div_step_s : mul_step_s;
                    end
                end
                FIX: begin
                    low_r  <= res_lo_s;
                    high_r <= res_hi_s;
                    dz_r   <= res_dz_s;
                    zero_r <= ({res_hi_s, res_lo_s} == {(2*WIDTH){1'b0}});
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    cnt_r  <= {CW{1'b0}};
                end
                default: begin
                    busy_r <= 1'b0;
                    cnt_r  <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign low_out  = low_r;
    assign high_out = high_r;
    assign dz       = dz_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=16): result table plus handshake/reset sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, dz, zero;
    logic [15:0] low_out, high_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    mul_div_unit #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .low_out(low_out), .high_out(high_out),
        .dz(dz), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b, lo, hi;
        logic        dz, zr;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic do_start(input logic [1:0] o, input logic [15:0] xa, input logic [15:0] xb);
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; op = 2'b01; a = 16'hDEAD; b = 16'hBEEF;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;

        vecs[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17};
        vecs[1]  = '{2'b01, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 17};
        vecs[2]  = '{2'b01, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 17};
        vecs[3]  = '{2'b10, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17};
        vecs[4]  = '{2'b11, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
        vecs[5]  = '{2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2};
        vecs[6]  = '{2'b10, 16'd9,    16'd3,    16'd3,    16'd0,    1'b0, 1'b0, 17};
        vecs[7]  = '{2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
        vecs[8]  = '{2'b10, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 17};
        vecs[9]  = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, 17};
        vecs[10] = '{2'b11, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17};
        vecs[11] = '{2'b11, 16'hFF00, 16'h0000, 16'hFFFF, 16'hFF00, 1'b1, 1'b0, 2};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst lo",   {16'd0, low_out}, 32'd0);
        check("rst hi",   {16'd0, high_out}, 32'd0);
        check("rst dz",   {31'd0, dz}, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_start(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("v%0d lat", i),  lat, vecs[i].lat);
            check($sformatf("v%0d busy", i), bcnt, vecs[i].lat);
            check($sformatf("v%0d lo", i),   {16'd0, low_out},  {16'd0, vecs[i].lo});
            check($sformatf("v%0d hi", i),   {16'd0, high_out}, {16'd0, vecs[i].hi});
            check($sformatf("v%0d dz", i),   {31'd0, dz},   {31'd0, vecs[i].dz});
            check($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].zr});
            @(posedge clk); #1;
            check($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d hold lo", i), {16'd0, low_out}, {16'd0, vecs[i].lo});
        end

        // start while busy is ignored
        do_start(2'b00, 16'd3, 16'd5);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 2) begin start = 1'b1; op = 2'b10; a = 16'd1; b = 16'd1; end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
        end
        check("ign lat", lat, 17);
        check("ign lo", {16'd0, low_out}, 32'd15);
        check("ign hi", {16'd0, high_out}, 32'd0);

        // back-to-back start in the done cycle; outputs hold during the new op
        start = 1'b1; op = 2'b01; a = 16'hFFFF; b = 16'h0002;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) check("b2b hold lo", {16'd0, low_out}, 32'd15);
        end
        check("b2b lat", lat, 17);
        check("b2b lo", {16'd0, low_out}, 32'h0000FFFE);
        check("b2b hi", {16'd0, high_out}, 32'h0000FFFF);

        // asynchronous reset mid-operation
        do_start(2'b00, 16'h00FF, 16'h0101);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst done", {31'd0, done}, 32'd0);
        check("arst lo", {16'd0, low_out}, 32'd0);
        check("arst hi", {16'd0, high_out}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("arst no done", seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
